// File: rtl/mem_wb_stage_if.sv
// MEM/WB stage bus: MEM-side offer, data-memory response and writeback outputs.
// The master drives the offer and memory response; the slave is the stage itself.
interface mem_wb_stage_if #(
    parameter int XLEN   = 32,
    parameter int REG_AW = 5
);
    logic              mem_valid;
    logic              mem_ready;
    logic              flush;
    logic [REG_AW-1:0] mem_rd_addr;
    logic              mem_rd_we;
    logic [1:0]        mem_wb_sel;
    logic [XLEN-1:0]   mem_result;
    logic [XLEN-1:0]   mem_pc;
    logic              mem_is_c;
    logic [1:0]        mem_ld_size;
    logic              mem_ld_unsigned;
    logic [1:0]        mem_byte_off;
    logic              dm_rvalid;
    logic [XLEN-1:0]   dm_rdata;
    logic              wb_valid;
    logic              wb_rd_we;
    logic [REG_AW-1:0] wb_rd_addr;
    logic [XLEN-1:0]   wb_rd_data;
    logic [XLEN-1:0]   wb_pc;
    logic              stall_req;

    modport master (
        output mem_valid, flush, mem_rd_addr, mem_rd_we, mem_wb_sel, mem_result,
               mem_pc, mem_is_c, mem_ld_size, mem_ld_unsigned, mem_byte_off,
               dm_rvalid, dm_rdata,
        input  mem_ready, wb_valid, wb_rd_we, wb_rd_addr, wb_rd_data, wb_pc, stall_req
    );

    modport slave (
        input  mem_valid, flush, mem_rd_addr, mem_rd_we, mem_wb_sel, mem_result,
               mem_pc, mem_is_c, mem_ld_size, mem_ld_unsigned, mem_byte_off,
               dm_rvalid, dm_rdata,
        output mem_ready, wb_valid, wb_rd_we, wb_rd_addr, wb_rd_data, wb_pc, stall_req
    );
endinterface

// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline stage: registers MEM results, waits on multi-cycle loads,
// extracts and extends load data, and presents the register-file write.
module mem_wb_stage #(
    parameter int XLEN   = 32,
    parameter int REG_AW = 5
) (
    input  logic          clk,
    input  logic          arstn,
    mem_wb_stage_if.slave bus
);
    localparam logic [1:0] SEL_ALU  = 2'd0;
    localparam logic [1:0] SEL_LOAD = 2'd1;
    localparam logic [1:0] SEL_LINK = 2'd2;

    typedef enum logic {S_IDLE, S_WAIT} state_e;

    state_e            state_q, state_d;
    logic              wb_valid_q, wb_valid_d;
    logic              wb_rd_we_q, wb_rd_we_d;
    logic [REG_AW-1:0] wb_rd_addr_q, wb_rd_addr_d;
    logic [XLEN-1:0]   wb_rd_data_q, wb_rd_data_d;
    logic [XLEN-1:0]   wb_pc_q, wb_pc_d;
    logic [1:0]        wb_sel_q, wb_sel_d;
    logic              killed_q, killed_d;
    logic [1:0]        ld_size_q, ld_size_d;
    logic              ld_uns_q, ld_uns_d;
    logic [1:0]        ld_off_q, ld_off_d;
    logic [REG_AW-1:0] ld_rd_q, ld_rd_d;
    logic              ld_we_q, ld_we_d;
    logic [XLEN-1:0]   ld_pc_q, ld_pc_d;

    function automatic logic [XLEN-1:0] extract(input logic [XLEN-1:0] word,
                                                input logic [1:0] size,
                                                input logic uns,
                                                input logic [1:0] off);
        logic [7:0]  lane_b;
        logic [15:0] lane_h;
        lane_b = word[{off, 3'b000} +: 8];
        lane_h = off[1] ? word[31:16] : word[15:0];
        case (size)
            2'd0:    extract = {{(XLEN-8){lane_b[7] & ~uns}}, lane_b};
            2'd1:    extract = {{(XLEN-16){lane_h[15] & ~uns}}, lane_h};
            default: extract = word;
        endcase
    endfunction

    always_comb begin
        state_d      = state_q;
        wb_valid_d   = 1'b0;
        wb_rd_we_d   = 1'b0;
        wb_rd_addr_d = wb_rd_addr_q;
        wb_rd_data_d = wb_rd_data_q;
        wb_pc_d      = wb_pc_q;
        wb_sel_d     = wb_sel_q;
        killed_d     = killed_q;
        ld_size_d    = ld_size_q;
        ld_uns_d     = ld_uns_q;
        ld_off_d     = ld_off_q;
        ld_rd_d      = ld_rd_q;
        ld_we_d      = ld_we_q;
        ld_pc_d      = ld_pc_q;
        case (state_q)
            S_IDLE: begin
                if (bus.mem_valid && !bus.flush) begin
                    wb_sel_d = bus.mem_wb_sel;
                    if (bus.mem_wb_sel == SEL_LOAD) begin
                        state_d   = S_WAIT;
                        killed_d  = 1'b0;
                        ld_size_d = bus.mem_ld_size;
                        ld_uns_d  = bus.mem_ld_unsigned;
                        ld_off_d  = bus.mem_byte_off;
                        ld_rd_d   = bus.mem_rd_addr;
                        ld_we_d   = bus.mem_rd_we;
                        ld_pc_d   = bus.mem_pc;
                    end else begin
                        wb_valid_d   = 1'b1;
                        wb_rd_we_d   = bus.mem_rd_we & (|bus.mem_rd_addr);
                        wb_rd_addr_d = bus.mem_rd_addr;
                        wb_pc_d      = bus.mem_pc;
                        wb_rd_data_d = (bus.mem_wb_sel == SEL_LINK)
                                     ? bus.mem_pc + (bus.mem_is_c ? XLEN'(2) : XLEN'(4))
                                     : bus.mem_result;
                    end
                end
            end
            S_WAIT: begin
                // A flushed load still drains its response so it cannot pair with a later load.
                if (bus.flush) killed_d = 1'b1;
                if (bus.dm_rvalid) begin
                    state_d      = S_IDLE;
                    killed_d     = 1'b0;
                    wb_valid_d   = 1'b1;
                    wb_rd_we_d   = ld_we_q & (|ld_rd_q) & ~(killed_q | bus.flush);
                    wb_rd_addr_d = ld_rd_q;
                    wb_pc_d      = ld_pc_q;
                    wb_rd_data_d = extract(bus.dm_rdata, ld_size_q, ld_uns_q, ld_off_q);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            state_q      <= S_IDLE;
            wb_valid_q   <= 1'b0;
            wb_rd_we_q   <= 1'b0;
            wb_rd_addr_q <= '0;
            wb_rd_data_q <= '0;
            wb_pc_q      <= '0;
            wb_sel_q     <= SEL_ALU;
            killed_q     <= 1'b0;
            ld_size_q    <= 2'd0;
            ld_uns_q     <= 1'b0;
            ld_off_q     <= 2'd0;
            ld_rd_q      <= '0;
            ld_we_q      <= 1'b0;
            ld_pc_q      <= '0;
        end else begin
            state_q      <= state_d;
            wb_valid_q   <= wb_valid_d;
            wb_rd_we_q   <= wb_rd_we_d;
            wb_rd_addr_q <= wb_rd_addr_d;
            wb_rd_data_q <= wb_rd_data_d;
            wb_pc_q      <= wb_pc_d;
            wb_sel_q     <= wb_sel_d;
            killed_q     <= killed_d;
            ld_size_q    <= ld_size_d;
            ld_uns_q     <= ld_uns_d;
            ld_off_q     <= ld_off_d;
            ld_rd_q      <= ld_rd_d;
            ld_we_q      <= ld_we_d;
            ld_pc_q      <= ld_pc_d;
        end
    end

    assign bus.mem_ready  = (state_q == S_IDLE);
    assign bus.stall_req  = (state_q != S_IDLE);
    assign bus.wb_valid   = wb_valid_q;
    assign bus.wb_rd_we   = wb_rd_we_q;
    assign bus.wb_rd_addr = wb_rd_addr_q;
    assign bus.wb_rd_data = wb_rd_data_q;
    assign bus.wb_pc      = wb_pc_q;
endmodule

// File: tb/tb_mem_wb_stage.sv
// Directed bench for mem_wb_stage: ALU/link/load writeback, flush, x0 and reset cases.
// Inputs change 1ns after a rising edge; outputs are sampled at that same point.
module tb_mem_wb_stage;
    logic clk;
    logic arstn;
    int   assertCount;
    int   failCount;

    localparam logic [31:0] LOAD_WORD = 32'h8A7F_F180;

    mem_wb_stage_if #(.XLEN(32), .REG_AW(5)) bus ();

    mem_wb_stage #(.XLEN(32), .REG_AW(5)) dut (
        .clk   (clk),
        .arstn (arstn),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        assertCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [1:0] sel, input logic [31:0] result,
                                 input logic [31:0] pc, input logic isC,
                                 input logic [4:0] rd, input logic we,
                                 input logic [1:0] size, input logic uns,
                                 input logic [1:0] off, input logic fl);
        bus.mem_wb_sel      = sel;
        bus.mem_result      = result;
        bus.mem_pc          = pc;
        bus.mem_is_c        = isC;
        bus.mem_rd_addr     = rd;
        bus.mem_rd_we       = we;
        bus.mem_ld_size     = size;
        bus.mem_ld_unsigned = uns;
        bus.mem_byte_off    = off;
        bus.mem_valid       = 1'b1;
        bus.flush           = fl;
        tick();
        bus.mem_valid       = 1'b0;
        bus.flush           = 1'b0;
    endtask

    // Load with the response arriving three cycles after the capture edge.
    task automatic runLoad(input string tag, input logic [1:0] size, input logic uns,
                           input logic [1:0] off, input logic [31:0] expected);
        applyStimulus(2'd1, 32'h0, 32'h0000_0200, 1'b0, 5'd3, 1'b1, size, uns, off, 1'b0);
        checkOutput({tag, " capture wb_valid"}, {31'b0, bus.wb_valid}, 32'd0);
        checkOutput({tag, " capture stall"}, {31'b0, bus.stall_req}, 32'd1);
        for (int i = 0; i < 2; i++) begin
            tick();
            checkOutput({tag, " wait ready"}, {31'b0, bus.mem_ready}, 32'd0);
            checkOutput({tag, " wait stall"}, {31'b0, bus.stall_req}, 32'd1);
        end
        bus.dm_rvalid = 1'b1;
        bus.dm_rdata  = LOAD_WORD;
        tick();
        bus.dm_rvalid = 1'b0;
        checkOutput({tag, " wb_valid"}, {31'b0, bus.wb_valid}, 32'd1);
        checkOutput({tag, " wb_rd_we"}, {31'b0, bus.wb_rd_we}, 32'd1);
        checkOutput({tag, " wb_rd_addr"}, {27'b0, bus.wb_rd_addr}, 32'd3);
        checkOutput({tag, " wb_pc"}, bus.wb_pc, 32'h0000_0200);
        checkOutput({tag, " data"}, bus.wb_rd_data, expected);
        checkOutput({tag, " ready"}, {31'b0, bus.mem_ready}, 32'd1);
    endtask

    initial begin
        assertCount = 0;
        failCount   = 0;
        arstn       = 1'b0;
        bus.mem_valid = 1'b0; bus.flush = 1'b0; bus.mem_rd_addr = '0; bus.mem_rd_we = 1'b0;
        bus.mem_wb_sel = 2'd0; bus.mem_result = '0; bus.mem_pc = '0; bus.mem_is_c = 1'b0;
        bus.mem_ld_size = 2'd0; bus.mem_ld_unsigned = 1'b0; bus.mem_byte_off = 2'd0;
        bus.dm_rvalid = 1'b0; bus.dm_rdata = '0;
        #3;
        checkOutput("reset wb_valid", {31'b0, bus.wb_valid}, 32'd0);
        checkOutput("reset wb_rd_data", bus.wb_rd_data, 32'd0);
        checkOutput("reset mem_ready", {31'b0, bus.mem_ready}, 32'd1);
        arstn = 1'b1;
        tick();

        applyStimulus(2'd0, 32'h1234_5678, 32'h0000_0040, 1'b0, 5'd5, 1'b1, 2'd0, 1'b0, 2'd0, 1'b0);
        checkOutput("alu wb_valid", {31'b0, bus.wb_valid}, 32'd1);
        checkOutput("alu wb_rd_we", {31'b0, bus.wb_rd_we}, 32'd1);
        checkOutput("alu wb_rd_addr", {27'b0, bus.wb_rd_addr}, 32'd5);
        checkOutput("alu wb_rd_data", bus.wb_rd_data, 32'h1234_5678);
        checkOutput("alu wb_pc", bus.wb_pc, 32'h0000_0040);
        tick();
        checkOutput("alu one-cycle wb_valid", {31'b0, bus.wb_valid}, 32'd0);
        checkOutput("alu hold data", bus.wb_rd_data, 32'h1234_5678);

        applyStimulus(2'd3, 32'hCAFE_0000, 32'h0000_0044, 1'b0, 5'd6, 1'b1, 2'd0, 1'b0, 2'd0, 1'b0);
        checkOutput("imm data", bus.wb_rd_data, 32'hCAFE_0000);
        applyStimulus(2'd2, 32'h0, 32'h0000_0100, 1'b1, 5'd1, 1'b1, 2'd0, 1'b0, 2'd0, 1'b0);
        checkOutput("link c data", bus.wb_rd_data, 32'h0000_0102);
        applyStimulus(2'd2, 32'h0, 32'h0000_0100, 1'b0, 5'd1, 1'b1, 2'd0, 1'b0, 2'd0, 1'b0);
        checkOutput("link data", bus.wb_rd_data, 32'h0000_0104);
        applyStimulus(2'd2, 32'h0, 32'hFFFF_FFFC, 1'b0, 5'd1, 1'b1, 2'd0, 1'b0, 2'd0, 1'b0);
        checkOutput("link wrap data", bus.wb_rd_data, 32'h0000_0000);
        applyStimulus(2'd0, 32'h0000_00AA, 32'h0000_0048, 1'b0, 5'd4, 1'b0, 2'd0, 1'b0, 2'd0, 1'b0);
        checkOutput("we0 wb_valid", {31'b0, bus.wb_valid}, 32'd1);
        checkOutput("we0 wb_rd_we", {31'b0, bus.wb_rd_we}, 32'd0);

        runLoad("lb3", 2'd0, 1'b0, 2'd3, 32'hFFFF_FF8A);
        runLoad("lbu0", 2'd0, 1'b1, 2'd0, 32'h0000_0080);
        runLoad("lb1", 2'd0, 1'b0, 2'd1, 32'hFFFF_FFF1);
        runLoad("lbu2", 2'd0, 1'b1, 2'd2, 32'h0000_007F);
        runLoad("lh2", 2'd1, 1'b0, 2'd2, 32'hFFFF_8A7F);
        runLoad("lh3", 2'd1, 1'b0, 2'd3, 32'hFFFF_8A7F);
        runLoad("lh0", 2'd1, 1'b0, 2'd0, 32'hFFFF_F180);
        runLoad("lhu0", 2'd1, 1'b1, 2'd0, 32'h0000_F180);
        runLoad("lw", 2'd2, 1'b0, 2'd1, 32'h8A7F_F180);

        bus.dm_rvalid = 1'b1;
        tick();
        bus.dm_rvalid = 1'b0;
        checkOutput("idle rvalid ignored", {31'b0, bus.wb_valid}, 32'd0);

        applyStimulus(2'd0, 32'h5555_5555, 32'h0000_0050, 1'b0, 5'd8, 1'b1, 2'd0, 1'b0, 2'd0, 1'b1);
        checkOutput("flush alu wb_valid", {31'b0, bus.wb_valid}, 32'd0);
        checkOutput("flush alu data held", bus.wb_rd_data, 32'h8A7F_F180);

        applyStimulus(2'd1, 32'h0, 32'h0000_0060, 1'b0, 5'd7, 1'b1, 2'd2, 1'b0, 2'd0, 1'b0);
        bus.flush = 1'b1;
        tick();
        bus.flush = 1'b0;
        checkOutput("flush wait ready", {31'b0, bus.mem_ready}, 32'd0);
        bus.dm_rvalid = 1'b1;
        bus.dm_rdata  = 32'h0BAD_F00D;
        tick();
        bus.dm_rvalid = 1'b0;
        checkOutput("killed wb_valid", {31'b0, bus.wb_valid}, 32'd1);
        checkOutput("killed wb_rd_we", {31'b0, bus.wb_rd_we}, 32'd0);
        checkOutput("killed data", bus.wb_rd_data, 32'h0BAD_F00D);
        checkOutput("killed ready", {31'b0, bus.mem_ready}, 32'd1);
        applyStimulus(2'd0, 32'h0000_0777, 32'h0000_0064, 1'b0, 5'd9, 1'b1, 2'd0, 1'b0, 2'd0, 1'b0);
        checkOutput("post-kill wb_rd_we", {31'b0, bus.wb_rd_we}, 32'd1);
        checkOutput("post-kill wb_rd_addr", {27'b0, bus.wb_rd_addr}, 32'd9);
        checkOutput("post-kill data", bus.wb_rd_data, 32'h0000_0777);

        applyStimulus(2'd0, 32'h0000_0123, 32'h0000_0068, 1'b0, 5'd0, 1'b1, 2'd0, 1'b0, 2'd0, 1'b0);
        checkOutput("x0 wb_valid", {31'b0, bus.wb_valid}, 32'd1);
        checkOutput("x0 wb_rd_we", {31'b0, bus.wb_rd_we}, 32'd0);

        applyStimulus(2'd1, 32'h0, 32'h0000_0070, 1'b0, 5'd10, 1'b1, 2'd2, 1'b0, 2'd0, 1'b0);
        tick();
        arstn = 1'b0;
        #1;
        checkOutput("rst wb_rd_data", bus.wb_rd_data, 32'd0);
        checkOutput("rst wb_pc", bus.wb_pc, 32'd0);
        checkOutput("rst mem_ready", {31'b0, bus.mem_ready}, 32'd1);
        #1;
        arstn = 1'b1;
        bus.dm_rvalid = 1'b1;
        bus.dm_rdata  = LOAD_WORD;
        tick();
        bus.dm_rvalid = 1'b0;
        checkOutput("rst stale rvalid", {31'b0, bus.wb_valid}, 32'd0);
        checkOutput("rst stale data", bus.wb_rd_data, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end
endmodule

// File: doc/mem_wb_stage.md
Name: mem_wb_stage

Overview:
- Parametrised MEM/WB pipeline stage for the RV32IMC core: registers MEM results toward writeback and selects the writeback value.
- Handles multi-cycle data-memory loads with a valid handshake, and extracts/sign-extends byte, half and word loads.
- Supports stall back-pressure, flush and compressed-instruction link values.
- Sits between the data-memory interface / MEM stage and the register-file write port; its outputs also feed the forwarding unit.

Parameters:
- XLEN, 32, data/PC width.
- REG_AW, 5, register address width.

Ports:
- clk  in  1  core clock, all state on rising edge.
- arstn  in  1  asynchronous active-low reset.
- mem_valid  in  1  MEM stage offers an instruction this cycle.
- mem_ready  out  1  stage accepts the offer (transfer = mem_valid & mem_ready).
- flush  in  1  discard the instruction offered this cycle.
- mem_rd_addr  in  REG_AW  destination register.
- mem_rd_we  in  1  destination write enable.
- mem_wb_sel  in  2  0=ALU, 1=LOAD, 2=LINK, 3=IMM.
- mem_result  in  XLEN  ALU or immediate result.
- mem_pc  in  XLEN  instruction PC.
- mem_is_c  in  1  instruction is compressed (link = pc+2, otherwise pc+4).
- mem_ld_size  in  2  0=byte, 1=half, 2=word.
- mem_ld_unsigned  in  1  zero-extend load.
- mem_byte_off  in  2  address bits [1:0] of the load.
- dm_rvalid  in  1  load data valid.
- dm_rdata  in  XLEN  raw aligned memory word.
- wb_valid  out  1  writeback happens this cycle.
- wb_rd_we  out  1  register write enable.
- wb_rd_addr  out  REG_AW  destination register.
- wb_rd_data  out  XLEN  writeback value.
- wb_pc  out  XLEN  retiring PC.
- stall_req  out  1  equals ~mem_ready.

Behaviour:
- Reset (arstn low, asynchronous): state IDLE; wb_valid, wb_rd_we, wb_rd_addr, wb_rd_data, wb_pc = 0; internal wb_sel = ALU; killed flag = 0.
- States:
  - IDLE: mem_ready = 1.
  - WAIT: load outstanding; mem_ready = 0.
- Transfer in IDLE with flush = 0 at cycle T:
  - sel ALU or IMM: wb_rd_data = mem_result at T+1.
  - sel LINK: wb_rd_data = mem_pc + (mem_is_c ? 2 : 4), modulo 2^XLEN, at T+1.
  - In both cases: wb_valid = 1 for exactly one cycle (T+1); wb_rd_addr and wb_pc are registered.
  - sel LOAD: capture control fields and go to WAIT; wb_valid = 0.
- WAIT:
  - dm_rvalid is ignored on the capture cycle itself; the earliest accepted response is at T+1.
  - On dm_rvalid at cycle R: register the extracted data, go to IDLE, wb_valid = 1 at R+1.
  - WAIT holds indefinitely while dm_rvalid = 0.
- Load extraction:
  - byte: byte lane = byte_off.
  - half: half lane = byte_off[1]; byte_off[0] is ignored.
  - word: byte_off is ignored.
  - Sign-extend from the lane MSB unless mem_ld_unsigned = 1, in which case zero-extend.
- Write enable: wb_rd_we = mem_rd_we & (rd_addr != 0) & ~killed, and is qualified by wb_valid. When wb_valid = 0, wb_rd_we = 0.
- Hold values: outside a wb_valid cycle, wb_rd_addr, wb_rd_data and wb_pc hold their last values.
- flush:
  - Any transfer offered in a cycle with flush = 1 is dropped; no WB.
  - flush during WAIT does not abort the load. It sets killed, the load still completes on dm_rvalid with wb_valid = 1 and wb_rd_we = 0, and killed clears on return to IDLE. This prevents a stale response from being matched to a later load.
- dm_rvalid while IDLE is ignored.
- mem_valid while WAIT: not accepted (mem_ready = 0); the MEM stage holds its inputs.
- Reset asserted mid-WAIT: immediate return to IDLE with all outputs at reset values; a later dm_rvalid is ignored.
- Throughput: one non-load per cycle; back-to-back loads limited by memory latency.

Test Plan:
1. ALU op: mem_wb_sel=0, mem_result=0x1234_5678, rd=5, valid at T → wb_valid=1 at T+1 only, wb_rd_we=1, wb_rd_addr=5, wb_rd_data=0x1234_5678.
2. Link: mem_pc=0x100 with mem_is_c=1 → wb_rd_data=0x102. Same with mem_is_c=0 → 0x104. mem_pc=0xFFFF_FFFC with mem_is_c=0 → 0x0000_0000.
3. Loads with dm_rdata=0x8A7F_F180 and dm_rvalid 3 cycles after capture; check mem_ready=0 and stall_req=1 throughout WAIT:
   - LB, off=3 → 0xFFFF_FF8A.
   - LBU, off=0 → 0x0000_0080.
   - LH, off=2 → 0xFFFF_8A7F.
   - LHU, off=0 → 0x0000_F180.
   - LW → 0x8A7F_F180.
4. Flush: flush=1 with an ALU op offered → no wb_valid. A load in WAIT then flush, dm_rvalid 2 cycles later → wb_valid=1, wb_rd_we=0, state IDLE; a following ALU op is accepted and written normally.
5. rd=x0: ALU write to rd=0 → wb_valid=1, wb_rd_we=0.
6. Reset: arstn low mid-WAIT → outputs zero immediately; dm_rvalid pulse after release → no wb_valid.
